// File: rtl/sseg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with shadow/display
// double buffering, leading-zero blanking, anti-ghost guard time and PWM dimming.
module sseg_scan #(
    parameter int DIGITS        = 4,
    parameter int GUARD_CYC     = 4000,
    parameter int STEP          = 3000,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blank_i,
    input  logic                  load_i,
    input  logic                  lzb_i,
    input  logic [3:0]            bright_i,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic                  frame_o
);

    localparam int CLK_DIV = GUARD_CYC + 15 * STEP;
    localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W   = $clog2(DIGITS);

    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // scan counters
    logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    // shadow (written by load_i) and display (copied once per frame) registers
    logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [4*DIGITS-1:0] dsp_data_q, dsp_data_d;
    logic [DIGITS-1:0]   dsp_dp_q, dsp_dp_d;
    logic [DIGITS-1:0]   dsp_blank_q, dsp_blank_d;

    // registered outputs
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                frame_q, frame_d;

    logic                div_wrap;
    logic                frame_end;
    logic                lit;
    logic [31:0]         cnt_ext;
    logic [31:0]         win_hi;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_dark;
    logic                upper_zero;
    logic [DIGITS-1:0]   an_on;

    always_comb begin
        div_wrap  = (div_cnt_q == DIV_LAST);
        frame_end = div_wrap && (idx_q == IDX_LAST);

        div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (div_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        sh_data_d  = load_i ? data_i  : sh_data_q;
        sh_dp_d    = load_i ? dp_i    : sh_dp_q;
        sh_blank_d = load_i ? blank_i : sh_blank_q;

        // the display takes the shadow as it was before any load in this same cycle
        dsp_data_d  = frame_end ? sh_data_q  : dsp_data_q;
        dsp_dp_d    = frame_end ? sh_dp_q    : dsp_dp_q;
        dsp_blank_d = frame_end ? sh_blank_q : dsp_blank_q;
    end

    assign cnt_ext = 32'(div_cnt_q);
    assign win_hi  = 32'(GUARD_CYC) + 32'(bright_i) * 32'(STEP);
    assign lit     = (cnt_ext >= 32'(GUARD_CYC)) && (cnt_ext < win_hi);

    always_comb begin
        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_dark   = 1'b1;
        an_on      = '0;
        upper_zero = 1'b1;
        // walk from the top digit down so upper_zero covers nibbles k..DIGITS-1
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (dsp_data_q[4*k +: 4] == 4'h0);
            if (idx_q == IDX_W'(k)) begin
                cur_nib  = dsp_data_q[4*k +: 4];
                cur_dp   = dsp_dp_q[k];
                cur_dark = dsp_blank_q[k] || (lzb_i && (k > 0) && upper_zero);
                an_on[k] = 1'b1;
            end
        end
    end

    always_comb begin
        an_d  = lit ? (an_on ^ AN_OFF) : AN_OFF;
        seg_d = seg_q;
        dp_d  = dp_q;
        // segments only move while every anode is off, so nothing ghosts
        if (!lit) begin
            seg_d = cur_dark ? 7'b1111111 : seg_decode(cur_nib);
            dp_d  = cur_dark | ~cur_dp;
        end
        frame_d = frame_end;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q   <= '0;
            idx_q       <= '0;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '1;
            dsp_data_q  <= '0;
            dsp_dp_q    <= '0;
            dsp_blank_q <= '1;
            an_q        <= AN_OFF;
            seg_q       <= 7'b1111111;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            sh_data_q   <= sh_data_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            dsp_data_q  <= dsp_data_d;
            dsp_dp_q    <= dsp_dp_d;
            dsp_blank_q <= dsp_blank_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            frame_q     <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign frame_o = frame_q;

endmodule
